// File: rtl/depth_line_buffer.sv
// depth_line_buffer: ping-pong line buffer between the Mandelbrot line engine
// and the colour LUT / stream packer. The engine fills one bank by address
// while the other bank drains in raster order over a valid/ready handshake.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   wr_we/wr_addr/wr_din  engine result write (addr >= X_SIZE ignored)
//   wr_line_done      current write bank complete (engine module_done)
//   wr_ready          a free bank exists; gates the engine start pulse
//   rd_valid/rd_ready drain handshake, one pixel per cycle
//   rd_depth/rd_x/rd_y current pixel depth and raster position
//   rd_eol/rd_sof     end-of-line / start-of-frame, qualify with rd_valid
//   ovf               sticky: write or line_done while no bank was free
//   ovf_count         dropped line count
//
// Optional: define DEPTH_LINE_BUF_OVF_CNT_EN to build a 16-bit saturating
// dropped-line counter on ovf_count; otherwise ovf_count is tied to zero.

module depth_line_buffer #(
    parameter int X_SIZE  = 640,
    parameter int Y_SIZE  = 480,
    parameter int DEPTH_W = 10,
    localparam int ADDR_W = $clog2(X_SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_we,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DEPTH_W-1:0] wr_din,
    input  logic               wr_line_done,
    output logic               wr_ready,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [DEPTH_W-1:0] rd_depth,
    output logic [ADDR_W-1:0]  rd_x,
    output logic [8:0]         rd_y,
    output logic               rd_eol,
    output logic               rd_sof,
    output logic               ovf,
    output logic [15:0]        ovf_count
);

    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(X_SIZE - 1);
    localparam logic [8:0]        Y_LAST = 9'(Y_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_STREAM
    } state_t;

    state_t             state_q;
    logic [DEPTH_W-1:0] mem_q [2][X_SIZE];
    logic               wb_q;
    logic               rb_q;
    logic [1:0]         full_cnt_q;
    logic [1:0]         full_cnt_d;
    logic               rd_valid_q;
    logic [ADDR_W-1:0]  rd_x_q;
    logic [8:0]         rd_y_q;
    logic [DEPTH_W-1:0] rd_depth_q;
    logic               ovf_q;

    logic               wr_hit;
    logic               push;
    logic               fire;
    logic               pop;
    logic [ADDR_W-1:0]  x_nxt;

    assign wr_ready = (full_cnt_q < 2'd2);
    assign wr_hit   = wr_we && wr_ready && (32'(wr_addr) < X_SIZE);
    assign push     = wr_line_done && wr_ready;
    assign fire     = rd_valid_q && rd_ready;
    assign pop      = (state_q == ST_STREAM) && fire && rd_eol;
    assign x_nxt    = rd_x_q + ADDR_W'(1);

    assign rd_valid = rd_valid_q;
    assign rd_depth = rd_depth_q;
    assign rd_x     = rd_x_q;
    assign rd_y     = rd_y_q;
    assign rd_eol   = (rd_x_q == X_LAST);
    assign rd_sof   = (rd_x_q == '0) && (rd_y_q == '0);
    assign ovf      = ovf_q;

    // A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        full_cnt_d = full_cnt_q;
        if (push && !pop) begin
            full_cnt_d = full_cnt_q + 2'd1;
        end else if (pop && !push) begin
            full_cnt_d = full_cnt_q - 2'd1;
        end
    end

    // Bank storage is never cleared; a line is only drained once complete.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem_q[wb_q][wr_addr] <= wr_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            full_cnt_q <= 2'd0;
            rd_valid_q <= 1'b0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            full_cnt_q <= full_cnt_d;
            if (push) begin
                wb_q <= ~wb_q;
            end
            if ((wr_we || wr_line_done) && !wr_ready) begin
                ovf_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (full_cnt_q != 2'd0) begin
                        state_q <= ST_PRIME;
                    end
                end
                // RAM latency cycle: word 0 lands in the output register.
                ST_PRIME: begin
                    rd_depth_q <= mem_q[rb_q][0];
                    rd_valid_q <= 1'b1;
                    state_q    <= ST_STREAM;
                end
                // The next word is fetched on the handshake edge itself,
                // so a continuously ready consumer sees no bubbles.
                ST_STREAM: begin
                    if (fire) begin
                        if (rd_eol) begin
                            rd_valid_q <= 1'b0;
                            rd_x_q     <= '0;
                            rd_y_q     <= (rd_y_q == Y_LAST) ? 9'd0
                                                             : rd_y_q + 9'd1;
                            rb_q       <= ~rb_q;
                            state_q    <= ST_IDLE;
                        end else begin
                            rd_x_q     <= x_nxt;
                            rd_depth_q <= mem_q[rb_q][x_nxt];
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DEPTH_LINE_BUF_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt_q <= 16'd0;
        end else if (wr_line_done && !wr_ready && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = 16'd0;
`endif

endmodule

// File: tb/tb_depth_line_buffer.sv
// tb_depth_line_buffer: randomized and directed bench for depth_line_buffer
// against a line-queue / beat-scoreboard reference model.

module tb_depth_line_buffer;

    localparam int X  = 8;
    localparam int Y  = 3;
    localparam int DW = 10;
    localparam int AW = $clog2(X);
`ifdef DEPTH_LINE_BUF_OVF_CNT_EN
    localparam int OVF_EXP = 1;
`else
    localparam int OVF_EXP = 0;
`endif

    typedef struct {
        int d;
        int x;
        int y;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_we = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_din = '0;
    logic          wr_line_done = 1'b0;
    logic          wr_ready;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_depth;
    logic [AW-1:0] rd_x;
    logic [8:0]    rd_y;
    logic          rd_eol;
    logic          rd_sof;
    logic          ovf;
    logic [15:0]   ovf_count;

    depth_line_buffer #(
        .X_SIZE (X),
        .Y_SIZE (Y),
        .DEPTH_W(DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_we       (wr_we),
        .wr_addr     (wr_addr),
        .wr_din      (wr_din),
        .wr_line_done(wr_line_done),
        .wr_ready    (wr_ready),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_depth    (rd_depth),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_eol      (rd_eol),
        .rd_sof      (rd_sof),
        .ovf         (ovf),
        .ovf_count   (ovf_count)
    );

    always #5 clk = ~clk;

    int    n_assert = 0;
    int    n_fail = 0;
    int    m_full = 0;
    bit    m_ovf = 1'b0;
    int    m_cnt = 0;
    int    m_y = 0;
    int    wline[X];
    beat_t exp_q[$];
    int    rdy_mode = 0;
    int    pat = 0;
    bit    s_valid;
    int    s_x;
    int    dut_fires = 0;
    int    sof_dut = 0;
    int    y_hist = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs at negedge, update the model at posedge.
    task automatic tick();
        bit    fire;
        bit    rdy;
        beat_t b;
        if (rdy_mode == 1) begin
            rd_ready = (pat % 3 == 0);
            pat++;
        end else if (rdy_mode == 2) begin
            rd_ready = $urandom_range(0, 1) == 1;
        end
        @(negedge clk);
        s_valid = rd_valid;
        s_x = int'(rd_x);
        chk("wr_ready", 32'(wr_ready), 32'(m_full < 2));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid_extra", 32'(rd_valid), 32'd0);
            end else begin
                b = exp_q[0];
                chk("rd_depth", 32'(rd_depth), 32'(b.d));
                chk("rd_x", 32'(rd_x), 32'(b.x));
                chk("rd_y", 32'(rd_y), 32'(b.y));
                chk("rd_eol", 32'(rd_eol), 32'(b.x == X - 1));
                chk("rd_sof", 32'(rd_sof), 32'(b.x == 0 && b.y == 0));
            end
        end
        fire = rd_valid && rd_ready;
        if (fire) begin
            dut_fires++;
            if (rd_sof) sof_dut++;
            if (rd_x == '0) y_hist = (y_hist << 2) | int'(rd_y);
        end
        @(posedge clk);
        if (reset) begin
            m_full = 0;
            m_ovf = 1'b0;
            m_cnt = 0;
            m_y = 0;
            exp_q.delete();
        end else begin
            rdy = (m_full < 2);
            if (wr_we) begin
                if (!rdy) m_ovf = 1'b1;
                else if (int'(wr_addr) < X) wline[wr_addr] = int'(wr_din);
            end
            if (wr_line_done) begin
                if (rdy) begin
                    m_full++;
                    for (int i = 0; i < X; i++) begin
                        b.d = wline[i];
                        b.x = i;
                        b.y = m_y;
                        exp_q.push_back(b);
                    end
                    m_y = (m_y + 1) % Y;
                end else begin
                    m_ovf = 1'b1;
                    if (OVF_EXP == 1 && m_cnt < 65535) m_cnt++;
                end
            end
            if (fire && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                if (b.x == X - 1) m_full--;
            end
        end
        #1;
    endtask

    task automatic wait_free();
        int n = 0;
        while (m_full >= 2 && n < 200) begin
            tick();
            n++;
        end
        if (m_full >= 2) chk("wr_ready_timeout", 32'(m_full), 32'd1);
    endtask

    task automatic write_words(input int base, input bit gaps);
        int idx[X];
        int j;
        int t;
        for (int i = 0; i < X; i++) idx[i] = i;
        for (int i = X - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = idx[i];
            idx[i] = idx[j];
            idx[j] = t;
        end
        for (int i = 0; i < X; i++) begin
            wait_free();
            wr_we = 1'b1;
            wr_addr = AW'(idx[i]);
            wr_din = (base < 0) ? DW'($urandom) : DW'(base + idx[i]);
            tick();
            wr_we = 1'b0;
            if (gaps && $urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic line_done();
        wait_free();
        wr_line_done = 1'b1;
        tick();
        wr_line_done = 1'b0;
    endtask

    task automatic write_line(input int base, input bit gaps);
        write_words(base, gaps);
        line_done();
    endtask

    task automatic drain(input int mode);
        int n = 0;
        rdy_mode = mode;
        pat = 0;
        if (mode == 0) rd_ready = 1'b1;
        while (exp_q.size() > 0 && n < 500) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
        rdy_mode = 0;
    endtask

    task automatic do_reset();
        rdy_mode = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        int nb;
        int f0;
        int s0;

        for (int i = 0; i < X; i++) wline[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_x", 32'(rd_x), 32'd0);
        chk("reset_rd_y", 32'(rd_y), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_ovf_count", 32'(ovf_count), 32'd0);

        // Single line: latency and back-to-back beats.
        rd_ready = 1'b1;
        write_words(0, 1'b0);
        line_done();
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!s_valid && cyc < 10);
        chk("t1_latency", 32'(cyc), 32'd3);
        nb = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!s_valid) break;
            nb++;
        end
        chk("t1_beats", 32'(nb), 32'(X));
        chk("t1_drained", 32'(exp_q.size()), 32'd0);

        // Back-pressure with a 1,0,0 ready pattern.
        do_reset();
        rd_ready = 1'b0;
        write_line(0, 1'b0);
        f0 = dut_fires;
        drain(1);
        chk("t2_fires", 32'(dut_fires - f0), 32'(X));

        // Ping-pong fill while stalled, then overflow.
        do_reset();
        rd_ready = 1'b0;
        write_line(100, 1'b1);
        write_line(200, 1'b1);
        tick();
        chk("t3_wr_ready_full", 32'(wr_ready), 32'd0);
        wr_we = 1'b1;
        wr_addr = '0;
        wr_din = DW'(999);
        wr_line_done = 1'b1;
        tick();
        wr_we = 1'b0;
        wr_line_done = 1'b0;
        tick();
        chk("t4_ovf", 32'(ovf), 32'd1);
        chk("t4_ovf_count", 32'(ovf_count), 32'(OVF_EXP));
        f0 = dut_fires;
        drain(0);
        chk("t4_fires", 32'(dut_fires - f0), 32'(2 * X));

        // Reset mid-stream at beat 3.
        rd_ready = 1'b1;
        write_line(-1, 1'b0);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(s_valid && s_x == 3) && cyc < 30);
        chk("t6_reach_beat3", 32'(s_x), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("t6_rd_valid", 32'(s_valid), 32'd0);
        chk("t6_wr_ready", 32'(wr_ready), 32'd1);
        chk("t6_ovf", 32'(ovf), 32'd0);
        write_line(-1, 1'b1);
        drain(0);

        // Frame wrap over four lines.
        do_reset();
        s0 = sof_dut;
        y_hist = 0;
        for (int l = 0; l < 4; l++) begin
            write_line(-1, 1'b1);
            drain(0);
        end
        chk("t5_sof_count", 32'(sof_dut - s0), 32'd2);
        chk("t5_y_seq", 32'(y_hist), 32'h18);

        // Random soak: concurrent fill and drain with random ready.
        do_reset();
        rdy_mode = 2;
        for (int l = 0; l < 24; l++) begin
            write_line(-1, 1'b1);
        end
        drain(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
